scpad_xbar_rd: RTL and testbench
================================

Name: scpad_xbar_rd

Overview:
- Scratchpad read crossbar stage, directly downstream of the swizzle stage.
- Consumes one crossbar descriptor per request: per logical lane a valid bit, a physical bank index (shift) and a bank row (slot).
- Issues one read per physical bank, waits the fixed SRAM latency, then un-permutes the bank outputs back into logical lane order.
- Returns one vector per request through a credit-protected response FIFO. Banks cannot be stalled, so the FIFO must never overflow.

Parameters:
- NUM_COLS, 32, lanes = banks; power of two.
- ROW_IDX_WIDTH, 10, bank slot index width.
- COL_IDX_WIDTH, $clog2(NUM_COLS), bank index width.
- ELEM_WIDTH, 16, bits per bank word.
- TAG_WIDTH, 4, request tag passed through unchanged.
- BANK_LAT, 1, SRAM read latency in cycles; must be >= 1.
- RSP_DEPTH, 4, response FIFO entries; must be >= BANK_LAT+1 for full throughput.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- req_valid  in  1  descriptor valid.
- req_ready  out  1  descriptor accepted when valid && ready.
- req_valid_mask  in  NUM_COLS  per-lane valid.
- req_shift_mask  in  NUM_COLS*COL_IDX_WIDTH  per-lane physical bank; lane i in bits [i*CIW +: CIW].
- req_slot_mask  in  NUM_COLS*ROW_IDX_WIDTH  per-lane bank row.
- req_tag  in  TAG_WIDTH  request id.
- bank_rd_en  out  NUM_COLS  per-bank read strobe.
- bank_rd_slot  out  NUM_COLS*ROW_IDX_WIDTH  per-bank read row.
- bank_rdata  in  NUM_COLS*ELEM_WIDTH  per-bank data, valid BANK_LAT cycles after the strobe.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  NUM_COLS*ELEM_WIDTH  lane-ordered data.
- rsp_lane_mask  out  NUM_COLS  copy of the request's valid mask.
- rsp_tag  out  TAG_WIDTH  tag of the request.
- err_conflict  out  1  one-cycle pulse on accepting a request with a bank conflict.

Behaviour:
- Reset (async, nRST=0): FIFO emptied, all in-flight entries dropped, credit count=0. Outputs: bank_rd_en=0, bank_rd_slot=0, rsp_valid=0, rsp_data=0, rsp_lane_mask=0, rsp_tag=0, err_conflict=0. req_ready=1 after reset because it is derived from count=0. Reads in flight when reset asserts are discarded; bank_rdata arriving after reset is ignored.
- Credit: cnt = in-flight + FIFO occupancy, range 0..RSP_DEPTH.
  - req_ready = (cnt < RSP_DEPTH), combinational from registered cnt.
  - +1 on accept, -1 on rsp handshake, unchanged when both occur in the same cycle.
  - req_ready never depends on rsp_ready.
- Issue, cycle T = accept cycle, combinational:
  - For each bank b, bank_rd_en[b] = OR over lanes i of (valid_mask[i] && shift[i]==b).
  - bank_rd_slot[b] = slot of the lowest such lane i; 0 when no lane targets bank b.
  - No strobes when there is no accept.
- Conflict: two valid lanes with the same shift.
  - err_conflict pulses (registered, visible at T+1).
  - Lowest lane wins the bank; losing lanes return 0 and keep their rsp_lane_mask bit.
- In-flight pipe: BANK_LAT-deep shift register of {valid, valid_mask, shift_mask, conflict-loser mask, tag}. One push per accept; bubbles carry valid=0.
- Return at cycle T+BANK_LAT:
  - rsp lane i = bank_rdata[shift[i]] when the lane is valid and not a loser, else 0.
  - The result is written to the FIFO at that clock edge.
- Latency: accept at T gives rsp_valid at T+BANK_LAT+1 when the FIFO was empty.
- Throughput: 1 request/cycle sustained when rsp_ready=1 and RSP_DEPTH >= BANK_LAT+1.
- FIFO: rsp_* driven from the head entry, stable while rsp_valid && !rsp_ready. Ordering is strictly in order. A push into a full FIFO is impossible by the credit rule; the bench asserts this.
- Empty FIFO with a simultaneous push: rsp_valid rises the next cycle. There is no bypass.
- Pointers wrap modulo RSP_DEPTH.

Decomposition:
- scpad_pkg gains the lane-ordered response struct xbar_rd_rsp_t {data, lane_mask, tag}.
- NUM_COLS, ROW_IDX_WIDTH, COL_IDX_WIDTH and the descriptor fields are reused from scpad_pkg.
- Sub-module scpad_rsp_fifo: synchronous FIFO with parameterised depth and width, async active-low reset, full/empty/count outputs.

Test Plan:
- Bench config NUM_COLS=4, BANK_LAT=1, RSP_DEPTH=4. Bank b slot s preloaded with 8'h{b,s}.
- Row-major row 1: valid=4'hF, shift=[1,0,3,2], slot=1 -> bank_rd_en=4'hF at T; rsp_data lanes=[0x11,0x01,0x31,0x21] at T+2; err_conflict=0.
- Partial mask 4'b0011, shift=[2,3,x,x], slot=[5,6,x,x] -> bank_rd_en=4'b1100; rsp lanes=[0x25,0x36,0,0]; rsp_lane_mask=4'b0011.
- Conflict: valid=4'hF, shift=[0,0,1,2], slot=[3,7,3,3] -> err_conflict pulse at T+1; bank_rd_slot[0]=3; lanes=[0x03,0,0x13,0x23].
- Backpressure: rsp_ready=0, 6 back-to-back requests -> exactly 4 accepted, req_ready=0 from then on. Release rsp_ready -> 4 responses in tag order, then remaining requests accepted.
- Reset mid-flight: assert nRST low 1 cycle after an accept -> no rsp_valid ever for that tag; cnt=0; req_ready=1 immediately after release.

Source files
------------

// File: rtl/scpad_pkg.sv
// Shared scratchpad types and default geometry for the read datapath.
// Blocks take these as parameter defaults so benches can shrink the geometry.
package scpad_pkg;

  localparam int NUM_COLS      = 32;
  localparam int ROW_IDX_WIDTH = 10;
  localparam int COL_IDX_WIDTH = $clog2(NUM_COLS);
  localparam int ELEM_WIDTH    = 16;
  localparam int TAG_WIDTH     = 4;
  localparam int BANK_LAT      = 1;
  localparam int RSP_DEPTH     = 4;

  typedef logic [COL_IDX_WIDTH-1:0] col_idx_t;
  typedef logic [ROW_IDX_WIDTH-1:0] row_idx_t;

  // Per-request crossbar descriptor as produced by the swizzle stage.
  typedef struct packed {
    logic [NUM_COLS-1:0]               valid_mask;
    logic [NUM_COLS*COL_IDX_WIDTH-1:0] shift_mask;
    logic [NUM_COLS*ROW_IDX_WIDTH-1:0] slot_mask;
    logic [TAG_WIDTH-1:0]              tag;
  } xbar_desc_t;

  // Lane-ordered read response returned to the requester.
  typedef struct packed {
    logic [NUM_COLS*ELEM_WIDTH-1:0] data;
    logic [NUM_COLS-1:0]            lane_mask;
    logic [TAG_WIDTH-1:0]           tag;
  } xbar_rd_rsp_t;

endpackage

// File: rtl/scpad_rsp_fifo.sv
// Synchronous FIFO with parameterised depth/width; pointers wrap modulo DEPTH,
// so the depth need not be a power of two.
module scpad_rsp_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: sequential state is updated with non-blocking '<=' so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers/count define which
  // entries are live, and a reset on the array would cost a flop reset tree.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/scpad_xbar_rd.sv
// Scratchpad read crossbar: scatters one descriptor into per-bank reads, then
// gathers the bank words back into lane order behind a credit-guarded FIFO.
module scpad_xbar_rd #(
  parameter int NUM_COLS      = scpad_pkg::NUM_COLS,
  parameter int ROW_IDX_WIDTH = scpad_pkg::ROW_IDX_WIDTH,
  parameter int COL_IDX_WIDTH = $clog2(NUM_COLS),
  parameter int ELEM_WIDTH    = scpad_pkg::ELEM_WIDTH,
  parameter int TAG_WIDTH     = scpad_pkg::TAG_WIDTH,
  parameter int BANK_LAT      = scpad_pkg::BANK_LAT,
  parameter int RSP_DEPTH     = scpad_pkg::RSP_DEPTH
) (
  input  logic                              CLK,
  input  logic                              nRST,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [NUM_COLS-1:0]               req_valid_mask,
  input  logic [NUM_COLS*COL_IDX_WIDTH-1:0] req_shift_mask,
  input  logic [NUM_COLS*ROW_IDX_WIDTH-1:0] req_slot_mask,
  input  logic [TAG_WIDTH-1:0]              req_tag,
  output logic [NUM_COLS-1:0]               bank_rd_en,
  output logic [NUM_COLS*ROW_IDX_WIDTH-1:0] bank_rd_slot,
  input  logic [NUM_COLS*ELEM_WIDTH-1:0]    bank_rdata,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [NUM_COLS*ELEM_WIDTH-1:0]    rsp_data,
  output logic [NUM_COLS-1:0]               rsp_lane_mask,
  output logic [TAG_WIDTH-1:0]              rsp_tag,
  output logic                              err_conflict
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic [NUM_COLS*ELEM_WIDTH-1:0] data;
    logic [NUM_COLS-1:0]            lane_mask;
    logic [TAG_WIDTH-1:0]           tag;
  } rsp_t;

  typedef struct packed {
    logic [NUM_COLS-1:0]               valid_mask;
    logic [NUM_COLS*COL_IDX_WIDTH-1:0] shift_mask;
    logic [NUM_COLS-1:0]               loser_mask;
    logic [TAG_WIDTH-1:0]              tag;
  } flight_t;

  logic [CNT_W-1:0]                  cnt;
  logic                              accept;
  logic                              rsp_fire;
  logic [NUM_COLS-1:0]               claimed;
  logic [NUM_COLS-1:0]               loser;
  logic [NUM_COLS*ROW_IDX_WIDTH-1:0] claim_slot;
  logic [BANK_LAT-1:0]               fl_valid;
  flight_t                           fl_q [BANK_LAT];
  flight_t                           ret;
  rsp_t                              push_rsp;
  rsp_t                              head;
  rsp_t                              rsp_out;
  logic                              fifo_push;
  logic                              fifo_full;
  logic                              fifo_empty;
  logic [CNT_W-1:0]                  fifo_count;

  // Credits cover in-flight reads as well as queued responses, because the
  // banks cannot be stalled once a read is issued.
  assign req_ready = (cnt < CNT_W'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else begin
      case ({accept, rsp_fire})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Walking lanes upward, the first lane to name a bank claims it and sets its
  // row; any later lane naming the same bank is a conflict loser.
  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    claimed    = '0;
    loser      = '0;
    claim_slot = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (req_valid_mask[i]) begin
        if (claimed[req_shift_mask[i*COL_IDX_WIDTH +: COL_IDX_WIDTH]]) begin
          loser[i] = 1'b1;
        end else begin
          claimed[req_shift_mask[i*COL_IDX_WIDTH +: COL_IDX_WIDTH]] = 1'b1;
          claim_slot[int'(req_shift_mask[i*COL_IDX_WIDTH +: COL_IDX_WIDTH])*ROW_IDX_WIDTH +: ROW_IDX_WIDTH]
            = req_slot_mask[i*ROW_IDX_WIDTH +: ROW_IDX_WIDTH];
        end
      end
    end
  end

  assign bank_rd_en   = accept ? claimed    : '0;
  assign bank_rd_slot = accept ? claim_slot : '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      err_conflict <= 1'b0;
      fl_valid     <= '0;
    end else begin
      err_conflict <= accept && (|loser);
      fl_valid[0]  <= accept;
      for (int k = 1; k < BANK_LAT; k++) fl_valid[k] <= fl_valid[k-1];
    end
  end

  // Payload travels alongside the valid bits; bubbles carry stale payload.
  always_ff @(posedge CLK) begin
    fl_q[0] <= {req_valid_mask, req_shift_mask, loser, req_tag};
    for (int k = 1; k < BANK_LAT; k++) fl_q[k] <= fl_q[k-1];
  end

  assign ret       = fl_q[BANK_LAT-1];
  assign fifo_push = fl_valid[BANK_LAT-1];

  always_comb begin
    push_rsp.data      = '0;
    push_rsp.lane_mask = ret.valid_mask;
    push_rsp.tag       = ret.tag;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (ret.valid_mask[i] && !ret.loser_mask[i]) begin
        push_rsp.data[i*ELEM_WIDTH +: ELEM_WIDTH] =
          bank_rdata[int'(ret.shift_mask[i*COL_IDX_WIDTH +: COL_IDX_WIDTH])*ELEM_WIDTH +: ELEM_WIDTH];
      end
    end
  end

  scpad_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH ($bits(rsp_t))
  ) u_rsp_fifo (
    .clk     (CLK),
    .rst_n   (nRST),
    .push    (fifo_push),
    .wr_data (push_rsp),
    .pop     (rsp_fire),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign rsp_out       = fifo_empty ? '0 : head;
  assign rsp_valid     = !fifo_empty;
  assign rsp_data      = rsp_out.data;
  assign rsp_lane_mask = rsp_out.lane_mask;
  assign rsp_tag       = rsp_out.tag;

  a_no_overflow: assert property (@(posedge CLK) disable iff (!nRST) !(fifo_push && fifo_full));
  a_credit_cover: assert property (@(posedge CLK) disable iff (!nRST) fifo_count <= cnt);

endmodule

// File: tb/tb_scpad_xbar_rd.sv
// Bench for scpad_xbar_rd: directed literal cases plus randomized traffic
// checked every cycle against a queue-based model of the crossbar.
module tb_scpad_xbar_rd;

  localparam int NC    = 4;
  localparam int RIW   = 4;
  localparam int CIW   = 2;
  localparam int EW    = 8;
  localparam int TW    = 4;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              req_valid;
  logic              req_ready;
  logic [NC-1:0]     req_valid_mask;
  logic [NC*CIW-1:0] req_shift_mask;
  logic [NC*RIW-1:0] req_slot_mask;
  logic [TW-1:0]     req_tag;
  logic [NC-1:0]     bank_rd_en;
  logic [NC*RIW-1:0] bank_rd_slot;
  logic [NC*EW-1:0]  bank_rdata = '0;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [NC*EW-1:0]  rsp_data;
  logic [NC-1:0]     rsp_lane_mask;
  logic [TW-1:0]     rsp_tag;
  logic              err_conflict;

  scpad_xbar_rd #(
    .NUM_COLS      (NC),
    .ROW_IDX_WIDTH (RIW),
    .COL_IDX_WIDTH (CIW),
    .ELEM_WIDTH    (EW),
    .TAG_WIDTH     (TW),
    .BANK_LAT      (LAT),
    .RSP_DEPTH     (DEPTH)
  ) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_valid_mask (req_valid_mask),
    .req_shift_mask (req_shift_mask),
    .req_slot_mask  (req_slot_mask),
    .req_tag        (req_tag),
    .bank_rd_en     (bank_rd_en),
    .bank_rd_slot   (bank_rd_slot),
    .bank_rdata     (bank_rdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_lane_mask  (rsp_lane_mask),
    .rsp_tag        (rsp_tag),
    .err_conflict   (err_conflict)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bank b, row s holds 8'h{b,s}; unstrobed banks return noise.
  always @(posedge CLK) begin
    for (int b = 0; b < NC; b++)
      bank_rdata[b*EW +: EW] <= bank_rd_en[b] ? {2'b00, 2'(b), bank_rd_slot[b*RIW +: RIW]}
                                               : 8'($urandom);
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [NC*EW-1:0] data;
    logic [NC-1:0]    mask;
    logic [TW-1:0]    tag;
    int               rdy;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  logic err_exp = 1'b0;
  logic m_ready, m_acc, m_rv;
  exp_t m_ent;

  function automatic bit lane_wins(input logic [NC-1:0] vm, input logic [NC*CIW-1:0] sh, input int i);
    if (!vm[i]) return 1'b0;
    for (int j = 0; j < i; j++)
      if (vm[j] && sh[j*CIW +: CIW] == sh[i*CIW +: CIW]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [NC*EW-1:0] model_data(input logic [NC-1:0] vm, input logic [NC*CIW-1:0] sh,
                                                  input logic [NC*RIW-1:0] sl);
    logic [NC*EW-1:0] d = '0;
    for (int i = 0; i < NC; i++)
      if (lane_wins(vm, sh, i)) d[i*EW +: EW] = {2'b00, sh[i*CIW +: CIW], sl[i*RIW +: RIW]};
    return d;
  endfunction

  function automatic bit model_conflict(input logic [NC-1:0] vm, input logic [NC*CIW-1:0] sh);
    for (int i = 0; i < NC; i++)
      if (vm[i] && !lane_wins(vm, sh, i)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NC-1:0] model_en(input logic [NC-1:0] vm, input logic [NC*CIW-1:0] sh);
    logic [NC-1:0] e = '0;
    for (int b = 0; b < NC; b++)
      for (int i = 0; i < NC; i++)
        if (vm[i] && int'(sh[i*CIW +: CIW]) == b) e[b] = 1'b1;
    return e;
  endfunction

  function automatic logic [NC*RIW-1:0] model_slot(input logic [NC-1:0] vm, input logic [NC*CIW-1:0] sh,
                                                   input logic [NC*RIW-1:0] sl);
    logic [NC*RIW-1:0] s = '0;
    for (int b = 0; b < NC; b++)
      for (int i = NC - 1; i >= 0; i--)
        if (vm[i] && int'(sh[i*CIW +: CIW]) == b) s[b*RIW +: RIW] = sl[i*RIW +: RIW];
    return s;
  endfunction

  // Single compare process; inputs are stable between this edge and the next posedge.
  always @(negedge CLK) begin
    if (!nRST) begin
      q.delete();
      err_exp = 1'b0;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_req_ready", req_ready, 1);
      check("rst_bank_rd_en", bank_rd_en, 0);
      check("rst_bank_rd_slot", bank_rd_slot, 0);
      check("rst_err_conflict", err_conflict, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_lane_mask", rsp_lane_mask, 0);
      check("rst_rsp_tag", rsp_tag, 0);
    end else begin
      m_ready = (q.size() < DEPTH);
      m_acc   = req_valid && m_ready;
      check("req_ready", req_ready, m_ready);
      check("bank_rd_en", bank_rd_en, m_acc ? model_en(req_valid_mask, req_shift_mask) : '0);
      check("bank_rd_slot", bank_rd_slot,
            m_acc ? model_slot(req_valid_mask, req_shift_mask, req_slot_mask) : '0);
      check("err_conflict", err_conflict, err_exp);
      m_rv = (q.size() > 0) && (q[0].rdy <= cyc);
      check("rsp_valid", rsp_valid, m_rv);
      if (m_rv) begin
        check("rsp_data", rsp_data, q[0].data);
        check("rsp_lane_mask", rsp_lane_mask, q[0].mask);
        check("rsp_tag", rsp_tag, q[0].tag);
        if (rsp_ready) void'(q.pop_front());
      end
      if (dut.fifo_push) check("fifo_push_when_full", dut.fifo_full, 0);
      err_exp = m_acc && model_conflict(req_valid_mask, req_shift_mask);
      if (m_acc) begin
        m_ent.data = model_data(req_valid_mask, req_shift_mask, req_slot_mask);
        m_ent.mask = req_valid_mask;
        m_ent.tag  = req_tag;
        m_ent.rdy  = cyc + LAT + 1;
        q.push_back(m_ent);
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic directed(input string name, input logic [NC-1:0] vm, input logic [NC*CIW-1:0] sh,
                          input logic [NC*RIW-1:0] sl, input logic [TW-1:0] tg,
                          input logic [NC-1:0] exp_en, input logic [NC*RIW-1:0] exp_slot,
                          input logic exp_err, input logic [NC*EW-1:0] exp_data);
    @(posedge CLK); #1;
    req_valid = 1'b1; req_valid_mask = vm; req_shift_mask = sh; req_slot_mask = sl; req_tag = tg;
    @(negedge CLK);
    check({name, "_ready"}, req_ready, 1);
    check({name, "_en"}, bank_rd_en, exp_en);
    check({name, "_slot"}, bank_rd_slot, exp_slot);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(negedge CLK);
    check({name, "_err"}, err_conflict, exp_err);
    @(negedge CLK);
    check({name, "_rsp_valid"}, rsp_valid, 1);
    check({name, "_rsp_data"}, rsp_data, exp_data);
    check({name, "_rsp_mask"}, rsp_lane_mask, vm);
    check({name, "_rsp_tag"}, rsp_tag, tg);
  endtask

  int acc_cnt;
  int next_tag;
  int got[$];
  int thr_cnt;
  logic [TW-1:0] rnd_tag;

  initial begin
    nRST = 1'b0; req_valid = 1'b0; req_valid_mask = '0; req_shift_mask = '0;
    req_slot_mask = '0; req_tag = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;
    @(negedge CLK);
    check("post_reset_ready", req_ready, 1);

    // lanes [0..3]: shift=[1,0,3,2], slot=1
    directed("rowmajor", 4'hF, 8'hB1, 16'h1111, 4'h1, 4'hF, 16'h1111, 1'b0, 32'h2131_0111);
    // lanes 0,1 only: shift=[2,3], slot=[5,6]
    directed("partial", 4'b0011, 8'h0E, 16'h0065, 4'h2, 4'b1100, 16'h6500, 1'b0, 32'h0000_3625);
    // shift=[0,0,1,2], slot=[3,7,3,3]: lane 1 loses bank 0
    directed("conflict", 4'hF, 8'h90, 16'h3373, 4'h3, 4'b0111, 16'h0333, 1'b1, 32'h2313_0003);

    // Backpressure: six requests offered with the consumer stalled.
    acc_cnt = 0; next_tag = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge CLK); #1;
      rsp_ready = 1'b0; req_valid = 1'b1; req_valid_mask = 4'hF; req_shift_mask = 8'hE4;
      req_slot_mask = {4{4'(next_tag)}}; req_tag = 4'(next_tag);
      @(negedge CLK);
      if (req_ready) begin acc_cnt++; next_tag++; end
    end
    check("bp_accepted", acc_cnt, 4);
    check("bp_ready_low", req_ready, 0);
    got.delete();
    for (int c = 0; c < 40 && got.size() < 6; c++) begin
      @(posedge CLK); #1;
      rsp_ready = 1'b1;
      req_valid = (next_tag < 6);
      req_slot_mask = {4{4'(next_tag)}}; req_tag = 4'(next_tag);
      @(negedge CLK);
      if (rsp_valid && rsp_ready) got.push_back(int'(rsp_tag));
      if (req_valid && req_ready) next_tag++;
    end
    check("bp_rsp_count", got.size(), 6);
    for (int k = 0; k < got.size(); k++) check("bp_rsp_order", got[k], k);
    @(posedge CLK); #1; req_valid = 1'b0;

    // Reset one cycle after an accept: that request must vanish.
    repeat (3) @(posedge CLK);
    #1; req_valid = 1'b1; req_valid_mask = 4'hF; req_shift_mask = 8'hE4;
    req_slot_mask = 16'h9999; req_tag = 4'h9;
    @(negedge CLK);
    check("midrst_accept_ready", req_ready, 1);
    @(posedge CLK); #1; req_valid = 1'b0; nRST = 1'b0;
    @(posedge CLK); #1; nRST = 1'b1;
    check("midrst_cnt_zero", dut.cnt, 0);
    check("midrst_ready", req_ready, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      check("midrst_no_rsp", rsp_valid, 0);
    end

    // Sustained throughput: one accept per cycle with the consumer always ready.
    thr_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge CLK); #1;
      rsp_ready = 1'b1; req_valid = 1'b1;
      req_valid_mask = 4'($urandom); req_shift_mask = 8'($urandom);
      req_slot_mask = 16'($urandom); req_tag = 4'(c);
      @(negedge CLK);
      if (req_ready) thr_cnt++;
    end
    check("throughput", thr_cnt, 20);

    // Randomized traffic with random consumer stalls.
    rnd_tag = '0;
    for (int c = 0; c < 600; c++) begin
      @(posedge CLK); #1;
      req_valid      = ($urandom_range(0, 3) != 0);
      req_valid_mask = 4'($urandom);
      req_shift_mask = 8'($urandom);
      req_slot_mask  = 16'($urandom);
      req_tag        = rnd_tag;
      rnd_tag        = rnd_tag + 4'd1;
      rsp_ready      = (c % 100 < 30) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
    end

    @(posedge CLK); #1; req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (10) @(negedge CLK);
    check("drain_rsp_valid", rsp_valid, 0);
    check("drain_model_empty", q.size(), 0);
    check("drain_cnt", dut.cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
